// File: rtl/bcd_disp_pkg.sv
// Shared types and the BCD to 7-segment decoder for the display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF  = 7'b0000000;
   localparam seg_t SEG_DASH = 7'b1000000;

   function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
      seg_t s;
      case (bcd)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_display_scanner_scan_timer.sv
// Slot prescaler and digit index counter for the display scanner.
// adv marks the last cycle of a slot; wrap marks the last cycle of a frame.
module scan_timer #(
   parameter int SCAN_DIV   = 1000,
   parameter int NUM_DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [$clog2(NUM_DIGITS)-1:0] idx,
   output logic                          adv,
   output logic                          wrap
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [PW-1:0] pre;

   assign adv  = (pre == PW'(SCAN_DIV - 1));
   assign wrap = adv && (idx == IW'(NUM_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
      end else if (adv) begin
         pre <= '0;
         if (idx == IW'(NUM_DIGITS - 1))
            idx <= '0;
         else
            idx <= idx + 1'b1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Double-buffered multiplexed 7-segment scanner for NUM_DIGITS BCD digits.
// Optional leading-zero blanking is built when BCD_DISP_LZB_EN is defined.
module bcd_display_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                      CLK,
   input  logic                      MR_n,
   input  logic [4*NUM_DIGITS-1:0]   Digits,
   input  logic                      Latch,
   input  logic                      Blank,
   output logic [6:0]                Seg,
   output logic [NUM_DIGITS-1:0]     An,
   output logic                      Pending,
   output logic                      Frame
);

   import bcd_disp_pkg::*;

   localparam int IW = $clog2(NUM_DIGITS);

   logic [IW-1:0]           idx;
   logic                    adv;
   logic                    wrap;
   logic                    frame_end;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] active;
   logic [3:0]              digit;
   logic [NUM_DIGITS-1:0]   hot;
   logic                    slot_dark;

   scan_timer #(
      .SCAN_DIV   (SCAN_DIV),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_timer (
      .clk   (CLK),
      .rst_n (MR_n),
      .idx   (idx),
      .adv   (adv),
      .wrap  (wrap)
   );

   assign frame_end = adv & wrap;

   always_comb begin
      digit = 4'd0;
      hot   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            digit  = active[4*i +: 4];
            hot[i] = 1'b1;
         end
      end
   end

`ifdef BCD_DISP_LZB_EN
   logic [NUM_DIGITS-1:0] dark;

   // dark[i]: digit i and every more-significant digit are zero
   always_comb begin
      logic zeros;
      zeros = 1'b1;
      dark  = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zeros   = zeros & (active[4*i +: 4] == 4'd0);
         dark[i] = zeros;
      end
   end

   assign slot_dark = |(hot & dark);
`else
   assign slot_dark = 1'b0;
`endif

   // A latch landing on the frame boundary bypasses the shadow stage
   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         shadow  <= '0;
         active  <= '0;
         Pending <= 1'b0;
      end else if (Latch && frame_end) begin
         shadow  <= Digits;
         active  <= Digits;
         Pending <= 1'b0;
      end else if (Latch) begin
         shadow  <= Digits;
         Pending <= 1'b1;
      end else if (frame_end && Pending) begin
         active  <= shadow;
         Pending <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         Seg   <= SEG_OFF;
         An    <= '0;
         Frame <= 1'b0;
      end else begin
         Frame <= frame_end;
         if (Blank || slot_dark) begin
            Seg <= SEG_OFF;
            An  <= '0;
         end else begin
            Seg <= bcd_to_seg(digit);
            An  <= hot;
         end
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner (4 digits, 4-cycle slots).
// Expectations follow BCD_DISP_LZB_EN when it is defined.
module tb_bcd_display_scanner;

   logic        CLK = 1'b0;
   logic        MR_n;
   logic [15:0] Digits;
   logic        Latch;
   logic        Blank;
   logic [6:0]  Seg;
   logic [3:0]  An;
   logic        Pending;
   logic        Frame;

   int errors = 0;
   int checks = 0;
   int c = 0;

   localparam logic [27:0] S0000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
   localparam logic [27:0] S1234 = {7'h06, 7'h5B, 7'h4F, 7'h66};
   localparam logic [27:0] S9876 = {7'h6F, 7'h7F, 7'h07, 7'h7D};
   localparam logic [27:0] S1C05 = {7'h06, 7'h40, 7'h3F, 7'h6D};
   localparam logic [27:0] S0050 = {7'h3F, 7'h3F, 7'h6D, 7'h3F};

   bcd_display_scanner #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4)
   ) dut (
      .CLK     (CLK),
      .MR_n    (MR_n),
      .Digits  (Digits),
      .Latch   (Latch),
      .Blank   (Blank),
      .Seg     (Seg),
      .An      (An),
      .Pending (Pending),
      .Frame   (Frame)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] shown(input logic [15:0] v);
      logic [3:0] m;
      m = 4'hF;
`ifdef BCD_DISP_LZB_EN
      begin
         logic nz;
         nz = 1'b0;
         for (int i = 3; i > 0; i--) begin
            nz   = nz | (v[4*i +: 4] != 4'd0);
            m[i] = nz;
         end
      end
`endif
      return m;
   endfunction

   // One clock: optional latch, then check An/Seg/Frame for the value on show
   task automatic cyc(input logic [15:0] val, input logic [27:0] segs,
                      input logic lat, input logic [15:0] d);
      logic       bl;
      int         k;
      logic [3:0] ea;
      logic [6:0] es;
      Latch = lat;
      if (lat) Digits = d;
      bl = Blank;
      @(posedge CLK);
      #1;
      c++;
      Latch = 1'b0;
      k  = ((c - 1) / 4) % 4;
      ea = (4'b0001 << k) & shown(val);
      es = (ea != 4'd0) ? segs[k*7 +: 7] : 7'h00;
      if (bl) begin
         ea = 4'd0;
         es = 7'h00;
      end
      chk($sformatf("an c=%0d", c), An, ea);
      chk($sformatf("seg c=%0d", c), Seg, es);
      chk($sformatf("frame c=%0d", c), Frame, (c % 16 == 0));
   endtask

   initial begin
      MR_n   = 1'b0;
      Digits = 16'h0;
      Latch  = 1'b0;
      Blank  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst seg", Seg, 7'h00);
      chk("rst an", An, 4'h0);
      chk("rst pending", Pending, 1'b0);
      chk("rst frame", Frame, 1'b0);

      @(negedge CLK);
      MR_n = 1'b1;
      c = 0;
      repeat (16) cyc(16'h0, S0000, 1'b0, 16'h0);

      repeat (4) cyc(16'h0, S0000, 1'b0, 16'h0);
      cyc(16'h0, S0000, 1'b1, 16'h1234);
      chk("pend set", Pending, 1'b1);
      repeat (10) cyc(16'h0, S0000, 1'b0, 16'h0);
      chk("pend hold", Pending, 1'b1);
      cyc(16'h0, S0000, 1'b0, 16'h0);
      chk("pend drop", Pending, 1'b0);

      repeat (2) cyc(16'h1234, S1234, 1'b0, 16'h0);
      cyc(16'h1234, S1234, 1'b1, 16'h1111);
      repeat (4) cyc(16'h1234, S1234, 1'b0, 16'h0);
      cyc(16'h1234, S1234, 1'b1, 16'h9876);
      chk("pend relatch", Pending, 1'b1);
      repeat (8) cyc(16'h1234, S1234, 1'b0, 16'h0);
      chk("pend drop2", Pending, 1'b0);

      repeat (15) cyc(16'h9876, S9876, 1'b0, 16'h0);
      cyc(16'h9876, S9876, 1'b1, 16'h1C05);
      chk("bypass pend", Pending, 1'b0);

      repeat (6) cyc(16'h1C05, S1C05, 1'b0, 16'h0);
      Blank = 1'b1;
      repeat (10) cyc(16'h1C05, S1C05, 1'b0, 16'h0);
      Blank = 1'b0;
      repeat (4) cyc(16'h1C05, S1C05, 1'b0, 16'h0);
      cyc(16'h1C05, S1C05, 1'b1, 16'h1234);
      chk("pend pre-rst", Pending, 1'b1);

      #3;
      MR_n = 1'b0;
      #1;
      chk("mr seg", Seg, 7'h00);
      chk("mr an", An, 4'h0);
      chk("mr pending", Pending, 1'b0);
      chk("mr frame", Frame, 1'b0);
      @(negedge CLK);
      MR_n = 1'b1;
      c = 0;
      repeat (16) cyc(16'h0, S0000, 1'b0, 16'h0);
      chk("pend after rst", Pending, 1'b0);

      repeat (3) cyc(16'h0, S0000, 1'b0, 16'h0);
      cyc(16'h0, S0000, 1'b1, 16'h0050);
      repeat (12) cyc(16'h0, S0000, 1'b0, 16'h0);
      repeat (16) cyc(16'h0050, S0050, 1'b0, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the decade counter stage: takes NUM_DIGITS BCD digits (one 4-bit Q per decade counter, digit 0 = least significant) and time-multiplexes them onto one 7-segment bus with per-digit anode enables.
- Double-buffered, so a counter update never tears a displayed frame.
- Generates a per-frame strobe for downstream/bench synchronisation.

Parameters:
- NUM_DIGITS, 4, number of BCD digits scanned (>=2).
- SCAN_DIV, 1000, CLK cycles each digit stays lit (>=2).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- MR_n  input  1  asynchronous active-low master reset.
- Digits  input  4*NUM_DIGITS  BCD digits; digit i at bits [4i+3:4i].
- Latch  input  1  single-cycle request to capture Digits for display.
- Blank  input  1  level; forces display dark while high.
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- An  output  NUM_DIGITS  digit enables, one-hot active-high, all-zero when dark.
- Pending  output  1  a captured value is waiting for the frame boundary.
- Frame  output  1  one-cycle pulse when scan wraps to digit 0.

Behaviour:
- Reset (MR_n low, asynchronous):
  - prescaler=0, idx=0, shadow=0, active=0, Pending=0, Frame=0, Seg=0, An=0.
  - Mid-operation reset discards any pending capture.
- Prescaler: counts 0..SCAN_DIV-1. At terminal count it returns to 0 and idx advances. idx wraps NUM_DIGITS-1 -> 0.
- wrap event = terminal count with idx==NUM_DIGITS-1. Frame is registered high for exactly the cycle after the wrap event.
- Capture handshake:
  - Latch high: shadow <= Digits, Pending <= 1. A repeated Latch while Pending is set overwrites shadow; latest value wins.
  - On wrap event with Pending=1: active <= shadow, Pending <= 0.
  - Latch coincident with wrap event: active <= Digits directly (bypass), shadow <= Digits, Pending stays 0.
- Outputs are registered, one cycle after idx/active change:
  - An = one-hot of idx.
  - Seg = decode(active digit idx).
- Decode:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Codes 10..15 (invalid BCD) display a dash = 1000000.
- Blank high: Seg=0 and An=0 from the next cycle. Prescaler, idx and capture logic keep running. Deasserting Blank resumes on the current idx next cycle.
- First lit output after reset release: cycle 1, An=0001, Seg=0111111.

Optional Feature:
- Macro: BCD_DISP_LZB_EN (leading-zero blanking).
- Enabled: a digit i>0 is dark (An=0, Seg=0 in its slot) when active digit i and all more-significant active digits are 0. Digit 0 is never blanked. Invalid codes count as non-zero. Slot timing is unchanged.
- Disabled: all digits are always shown; no extra logic.

Decomposition:
- Package bcd_disp_pkg:
  - typedef seg_t (logic [6:0]).
  - constants SEG_OFF, SEG_DASH.
  - function bcd_to_seg(logic [3:0]) -> seg_t.
- Sub-module scan_timer (SCAN_DIV, NUM_DIGITS): prescaler plus idx counter. Outputs idx, adv (terminal count) and wrap.
- Capture registers and output registers stay in bcd_display_scanner.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4):
- Reset release, no Latch:
  - An cycles 0001,0010,0100,1000 every 4 clocks.
  - Seg=0111111 throughout.
  - Frame pulses every 16 clocks.
- Digits=16'h1234, Latch mid-frame:
  - Pending=1 until wrap; display unchanged.
  - After wrap: slots show 4,3,2,1 = 1100110,1001111,1011011,0000110.
  - Pending drops with the wrap.
- Latch 16'h1111 then 16'h9876 before wrap:
  - Next frame shows 9876 only.
  - Latch coincident with wrap event loads without Pending asserting.
- Digit value 4'hC:
  - Slot shows 1000000.
- Blank=1 for 10 cycles mid-slot:
  - An=0, Seg=0; idx keeps advancing.
  - Frame still pulses on schedule.
- MR_n low during Pending:
  - All outputs 0 immediately; Pending=0.
  - After release, display shows 0000.
  - With BCD_DISP_LZB_EN, 16'h0050 lights only digits 0 and 1.
